// File: rtl/dna_pkg.sv
// Shared definitions for the DNA storage controller read path:
// nucleotide ASCII codes, 2-bit symbol type and reader state encoding.
package dna_pkg;

    localparam int NUM_OF_NUCLEOTIDES = 40;
    localparam int ASCII_SIZE         = 8;

    localparam logic [7:0] NUC_A = 8'h41;
    localparam logic [7:0] NUC_C = 8'h43;
    localparam logic [7:0] NUC_G = 8'h47;
    localparam logic [7:0] NUC_T = 8'h54;

    // 2-bit nucleotide symbol: A=00, C=01, G=10, T=11
    typedef logic [1:0] nuc_sym_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        OUTPUT  = 2'd2
    } reader_state_t;

endpackage

// File: rtl/dna_strand_reader_decode.sv
// Combinational ASCII nucleotide decoder. Any byte that is not an
// uppercase A/C/G/T maps to symbol 00 with the erasure flag raised.
module nucleotide_decode
    import dna_pkg::*;
#(
    parameter int ASCII_SIZE = dna_pkg::ASCII_SIZE
) (
    input  logic [ASCII_SIZE-1:0] nuc_in,
    output nuc_sym_t              sym,
    output logic                  erasure
);

    // Map one character to its symbol; default branch covers erasures
    always_comb begin
        sym     = 2'b00;
        erasure = 1'b0;
        case (nuc_in)
            ASCII_SIZE'(NUC_A): sym = 2'b00;
            ASCII_SIZE'(NUC_C): sym = 2'b01;
            ASCII_SIZE'(NUC_G): sym = 2'b10;
            ASCII_SIZE'(NUC_T): sym = 2'b11;
            default:            erasure = 1'b1;
        endcase
    end

endmodule

// File: rtl/dna_strand_reader.sv
// Read-path front end: collects a strand of serial ASCII nucleotides and
// presents it as a packed 2-bit-per-symbol word plus per-position erasure
// mask and erasure count for the BCH decode path.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high. nuc_valid/nuc_in must be held until accepted; nuc_ready
// is high exactly while collecting. strand_valid stays high and all strand
// outputs stay stable until the edge where strand_ready is also high.
module dna_strand_reader
    import dna_pkg::*;
#(
    parameter int NUM_OF_NUCLEOTIDES = dna_pkg::NUM_OF_NUCLEOTIDES,
    parameter int ASCII_SIZE         = dna_pkg::ASCII_SIZE
) (
    input  logic                                    clk,
    input  logic                                    resetN,
    input  logic                                    start,
    input  logic [ASCII_SIZE-1:0]                   nuc_in,
    input  logic                                    nuc_valid,
    output logic                                    nuc_ready,
    output logic [2*NUM_OF_NUCLEOTIDES-1:0]         strand_out,
    output logic [NUM_OF_NUCLEOTIDES-1:0]           erasure_mask,
    output logic [$clog2(NUM_OF_NUCLEOTIDES+1)-1:0] erasure_count,
    output logic                                    strand_valid,
    input  logic                                    strand_ready,
    output logic                                    busy
);

    localparam int IDX_W = $clog2(NUM_OF_NUCLEOTIDES);
    localparam int CNT_W = $clog2(NUM_OF_NUCLEOTIDES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OF_NUCLEOTIDES - 1);

    reader_state_t    state;
    logic [IDX_W-1:0] index;
    nuc_sym_t         dec_sym;
    logic             dec_erasure;

    nucleotide_decode #(
        .ASCII_SIZE (ASCII_SIZE)
    ) u_decode (
        .nuc_in  (nuc_in),
        .sym     (dec_sym),
        .erasure (dec_erasure)
    );

    // Ready and busy follow the state register directly
    assign nuc_ready = (state == COLLECT);
    assign busy      = (state != IDLE);

    // Reader FSM: capture, shift-in, erasure tracking and strand handoff
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state         <= IDLE;
            index         <= '0;
            strand_out    <= '0;
            erasure_mask  <= '0;
            erasure_count <= '0;
            strand_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state         <= COLLECT;
                        index         <= '0;
                        strand_out    <= '0;
                        erasure_mask  <= '0;
                        erasure_count <= '0;
                    end
                end
                COLLECT: begin
                    if (nuc_valid) begin
                        // First nucleotide ends up in the MSBs after N shifts
                        strand_out    <= {strand_out[2*NUM_OF_NUCLEOTIDES-3:0], dec_sym};
                        erasure_mask  <= {erasure_mask[NUM_OF_NUCLEOTIDES-2:0], dec_erasure};
                        erasure_count <= erasure_count + CNT_W'(dec_erasure);
                        if (index == LAST_IDX) begin
                            state        <= OUTPUT;
                            strand_valid <= 1'b1;
                            index        <= '0;
                        end else begin
                            index <= index + 1'b1;
                        end
                    end
                end
                OUTPUT: begin
                    if (strand_ready) begin
                        strand_valid <= 1'b0;
                        if (start) begin
                            // Back-to-back strand: skip IDLE entirely
                            state         <= COLLECT;
                            index         <= '0;
                            strand_out    <= '0;
                            erasure_mask  <= '0;
                            erasure_count <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state        <= IDLE;
                    strand_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
